// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and default sizes for the instruction fetch scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_ctrl_pkg;

    // Defaults track the dual-issue instruction buffer geometry.
    localparam int DEF_BUF_DEPTH    = 32;
    localparam int DEF_MAX_INFLIGHT = 4;
    localparam int DEF_OCC_W        = 6;   // log2(DEF_BUF_DEPTH)+1
    localparam int DEF_INF_W        = 3;   // log2(DEF_MAX_INFLIGHT)+1

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ICache request/response, buffer push and issue pop signals of the fetch scheduler.
// Latency: n/a (wiring only).
// Backpressure: request is held off by the scheduler; responses and pops are never stalled.
interface inst_fetch_ctrl_if;

    logic fetch_req_o;
    logic fetch_ack_i;
    logic resp_valid_i;
    logic resp_inst1_valid_i;
    logic resp_inst2_valid_i;
    logic push_inst1_valid_o;
    logic push_inst2_valid_o;
    logic issue_i;
    logic issue_mode_i;

    // The scheduler drives requests and pushes.
    modport master (
        output fetch_req_o,
        output push_inst1_valid_o,
        output push_inst2_valid_o,
        input  fetch_ack_i,
        input  resp_valid_i,
        input  resp_inst1_valid_i,
        input  resp_inst2_valid_i,
        input  issue_i,
        input  issue_mode_i
    );

    // ICache, buffer and issue stage as seen from outside the scheduler.
    modport slave (
        input  fetch_req_o,
        input  push_inst1_valid_o,
        input  push_inst2_valid_o,
        output fetch_ack_i,
        output resp_valid_i,
        output resp_inst1_valid_i,
        output resp_inst2_valid_i,
        output issue_i,
        output issue_mode_i
    );

endinterface

// File: rtl/inst_fetch_ctrl_credit_counter.sv
// Up/down credit counter with synchronous clear (clear wins over inc/dec).
// Latency: count updates on the next clk; next value is also exported combinationally.
// Backpressure: none; callers keep the count within 0..2**W-1.
module inst_fetch_ctrl_credit_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [1:0]   inc_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: add incoming credits, remove consumed ones, or clear.
    always_comb begin
        cnt_d = cnt_q + {{(W-2){1'b0}}, inc_i} - {{(W-2){1'b0}}, dec_i};
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Credit-based ICache fetch scheduler in front of the dual-issue instruction buffer.
// Latency: request/push gating is combinational; counters and FSM update on the next clk.
// Backpressure: requests only issue when 2 buffer entries are reserved for every in-flight response.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int OCC_W        = DEF_OCC_W,
    parameter int INF_W        = DEF_INF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                fetch_stall_i,
    inst_fetch_ctrl_if.master   bus,
    output logic [OCC_W-1:0]    occupancy_o,
    output logic [INF_W-1:0]    inflight_o,
    output logic                buffer_full_o,
    output logic                draining_o
);

    localparam logic [OCC_W+1:0] NEED_MAX  = (OCC_W+2)'(BUF_DEPTH);
    localparam logic [INF_W-1:0] INF_MAX   = INF_W'(MAX_INFLIGHT);
    localparam logic [OCC_W-1:0] FULL_THR  = OCC_W'(BUF_DEPTH - 2);
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(BUF_DEPTH);

    fetch_state_e     state_q;
    logic [INF_W-1:0] discard_q;
    logic [INF_W-1:0] discard_d;
    logic             draining_q;

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [INF_W-1:0] inf_q;
    logic [INF_W-1:0] inf_d;

    logic             run;
    logic [OCC_W+1:0] need;
    logic             push1;
    logic             push2;
    logic [1:0]       push_cnt;
    logic [1:0]       pop_cnt;
    logic             accept;

    assign run = (state_q == FETCH_RUN);

    // Entries that would be committed if one more request were accepted.
    assign need = {2'b00, occ_q} + {{(OCC_W+1-INF_W){1'b0}}, inf_q, 1'b0} + (OCC_W+2)'(2);

    assign bus.fetch_req_o = run & ~flush & ~fetch_stall_i & (inf_q < INF_MAX) & (need <= NEED_MAX);
    assign accept          = bus.fetch_req_o & bus.fetch_ack_i;

    // Responses only reach the buffer while running; in DRAIN or on flush they are dropped.
    assign push1 = bus.resp_valid_i & bus.resp_inst1_valid_i & run & ~flush;
    assign push2 = bus.resp_valid_i & bus.resp_inst2_valid_i & run & ~flush;
    assign bus.push_inst1_valid_o = push1;
    assign bus.push_inst2_valid_o = push2;

    assign push_cnt = {1'b0, push1} + {1'b0, push2};
    assign pop_cnt  = bus.issue_i ? (bus.issue_mode_i ? 2'd2 : 2'd1) : 2'd0;

    inst_fetch_ctrl_credit_counter #(.W(OCC_W)) u_occ_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .inc_i     (push_cnt),
        .dec_i     (pop_cnt),
        .cnt_o     (occ_q),
        .cnt_nxt_o (occ_d)
    );

    inst_fetch_ctrl_credit_counter #(.W(INF_W)) u_inf_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (1'b0),
        .inc_i     ({1'b0, accept}),
        .dec_i     ({1'b0, bus.resp_valid_i}),
        .cnt_o     (inf_q),
        .cnt_nxt_o (inf_d)
    );

    assign discard_d = discard_q - INF_W'(bus.resp_valid_i);

    // Scheduler FSM: one IDLE cycle after reset, then RUN; DRAIN swallows stale responses after a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            discard_q  <= '0;
            draining_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    state_q <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (flush && (inf_d != '0)) begin
                        state_q    <= FETCH_DRAIN;
                        discard_q  <= inf_d;
                        draining_q <= 1'b1;
                    end
                end
                FETCH_DRAIN: begin
                    if (flush) begin
                        discard_q <= inf_d;
                        if (inf_d == '0) begin
                            state_q    <= FETCH_RUN;
                            draining_q <= 1'b0;
                        end
                    end else begin
                        discard_q <= discard_d;
                        if (discard_d == '0) begin
                            state_q    <= FETCH_RUN;
                            draining_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= FETCH_IDLE;
                    draining_q <= 1'b0;
                end
            endcase
        end
    end

    assign occupancy_o   = occ_q;
    assign inflight_o    = inf_q;
    assign buffer_full_o = (occ_q > FULL_THR);
    assign draining_o    = draining_q;

    // Illegal traffic from the neighbours and occupancy overflow.
    a_resp_without_req: assert property (@(posedge clk) disable iff (rst)
        !(bus.resp_valid_i && (inf_q == '0)));
    a_pop_underflow: assert property (@(posedge clk) disable iff (rst)
        flush || (({1'b0, occ_q} + (OCC_W+1)'(push_cnt)) >= (OCC_W+1)'(pop_cnt)));
    a_occ_overflow: assert property (@(posedge clk) disable iff (rst)
        occ_q <= OCC_LIMIT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl with a transaction-level model of the buffer credits.
// Latency: expectations are queued when stimulus is applied and checked half a cycle later.
// Backpressure: bench only issues legal responses (inflight>0) and legal pops (pop<=occ+push).
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int DEPTH = DEF_BUF_DEPTH;
    localparam int MAXF  = DEF_MAX_INFLIGHT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 stall = 1'b0;
    logic [DEF_OCC_W-1:0] occ;
    logic [DEF_INF_W-1:0] inf;
    logic                 full;
    logic                 drn;

    inst_fetch_ctrl_if bus_if ();

    inst_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .fetch_stall_i (stall),
        .bus           (bus_if),
        .occupancy_o   (occ),
        .inflight_o    (inf),
        .buffer_full_o (full),
        .draining_o    (drn)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit req;
        int occ;
        int inf;
        bit full;
        bit drn;
    } status_t;

    status_t  stat_q[$];
    bit [1:0] push_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;

    // Reference model: buffer entries, outstanding requests, stale responses still to drop.
    int m_occ;
    int m_inf;
    int m_stale;
    int m_age;      // cycles since reset release; the first one is the idle cycle
    bit m_drain;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ   = 0;
        m_inf   = 0;
        m_stale = 0;
        m_age   = 0;
        m_drain = 1'b0;
    endtask

    task automatic check_all_zero();
        check("rst_fetch_req", int'(bus_if.fetch_req_o), 0);
        check("rst_push1", int'(bus_if.push_inst1_valid_o), 0);
        check("rst_push2", int'(bus_if.push_inst2_valid_o), 0);
        check("rst_occupancy", int'(occ), 0);
        check("rst_inflight", int'(inf), 0);
        check("rst_full", int'(full), 0);
        check("rst_draining", int'(drn), 0);
    endtask

    // One clock of stimulus; called at a posedge, returns at the next posedge.
    task automatic step(input bit f, input bit st, input bit ack, input bit rv,
                        input bit s1, input bit s2, input bit iss, input bit md);
        status_t e;
        bit      running;
        bit      req;
        int      pushed;
        int      pop;
        int      inf_n;
        #1;
        if (m_inf == 0) rv = 1'b0;
        running = (m_age > 0) && !m_drain;
        pushed  = (rv && running && !f) ? (int'(s1) + int'(s2)) : 0;
        pop = 0;
        if (iss) begin
            pop = md ? 2 : 1;
            if (pop > m_occ + pushed) begin
                if (m_occ + pushed >= 1) begin
                    md  = 1'b0;
                    pop = 1;
                end else begin
                    iss = 1'b0;
                    pop = 0;
                end
            end
        end
        req = running && !f && !st && (m_inf < MAXF) && (m_occ + 2 * m_inf + 2 <= DEPTH);

        flush                     = f;
        stall                     = st;
        bus_if.fetch_ack_i        = ack;
        bus_if.resp_valid_i       = rv;
        bus_if.resp_inst1_valid_i = s1;
        bus_if.resp_inst2_valid_i = s2;
        bus_if.issue_i            = iss;
        bus_if.issue_mode_i       = md;

        e.req  = req;
        e.occ  = m_occ;
        e.inf  = m_inf;
        e.full = (m_occ >= DEPTH - 1);
        e.drn  = m_drain;
        stat_q.push_back(e);
        if (pushed > 0) push_q.push_back({s1, s2});

        inf_n = m_inf + ((req && ack) ? 1 : 0) - (rv ? 1 : 0);
        m_occ = f ? 0 : (m_occ + pushed - pop);
        if (f) begin
            m_stale = inf_n;
            m_drain = (inf_n > 0);
        end else if (m_drain) begin
            if (rv) m_stale--;
            if (m_stale == 0) m_drain = 1'b0;
        end
        m_inf = inf_n;
        if (m_age < 1000) m_age++;
        @(posedge clk);
    endtask

    task automatic step_random(input int flush_pct, input int issue_pct);
        step($urandom_range(0, 99) < flush_pct, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < issue_pct, 1'($urandom_range(0, 1)));
    endtask

    // Drain responses and buffer contents until the model is empty.
    task automatic settle();
        int n = 0;
        while ((m_inf > 0 || m_occ > 0 || m_drain) && n < 200) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        check("settle_bound", int'(n < 200), 1);
    endtask

    // Monitor: compares DUT outputs with queued expectations, away from the active edge.
    status_t  mon_e;
    bit [1:0] mon_p;
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.push_inst1_valid_o || bus_if.push_inst2_valid_o) begin
                if (push_q.size() == 0) begin
                    check("unexpected_push", 1, 0);
                end else begin
                    mon_p = push_q.pop_front();
                    check("push_slots", int'({bus_if.push_inst1_valid_o, bus_if.push_inst2_valid_o}), int'(mon_p));
                end
            end
            if (stat_q.size() > 0) begin
                mon_e = stat_q.pop_front();
                check("fetch_req", int'(bus_if.fetch_req_o), int'(mon_e.req));
                check("occupancy", int'(occ), mon_e.occ);
                check("inflight", int'(inf), mon_e.inf);
                check("buffer_full", int'(full), int'(mon_e.full));
                check("draining", int'(drn), int'(mon_e.drn));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, expected $finish before t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.fetch_ack_i        = 1'b0;
        bus_if.resp_valid_i       = 1'b0;
        bus_if.resp_inst1_valid_i = 1'b0;
        bus_if.resp_inst2_valid_i = 1'b0;
        bus_if.issue_i            = 1'b0;
        bus_if.issue_mode_i       = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;

        // Continuous ack, no responses: inflight climbs to the limit.
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // One response, then response + dual pop + ack together, then a slot-2-only response.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();

        // Flush with three requests outstanding and an ack in the flush cycle.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        // Fill the buffer with dual responses and no issue.
        repeat (60) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();

        // Random traffic, alternating light and heavy issue pressure.
        for (int i = 0; i < 1500; i++) begin
            step_random(3, ((i / 250) % 2 == 0) ? 15 : 60);
        end

        // Asynchronous reset in the middle of a drain.
        settle();
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        flush               = 1'b0;
        bus_if.fetch_ack_i  = 1'b0;
        bus_if.resp_valid_i = 1'b0;
        bus_if.issue_i      = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;
        model_reset();
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step_random(4, 40);
        end
        settle();

        @(negedge clk);
        #1;
        check("push_leftover", push_q.size(), 0);
        check("status_leftover", stat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
